ec_fp2_point_mult: RTL



---
 rtl/ec_fp2_point_mult.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ec_fp2_point_mult.sv
// rtl/ec_fp2_point_mult.sv - right-to-left double-and-add sequencer for Fp2 Jacobian points
// Optional build macro EC_PT_MULT_CONST_TIME_EN: fixed SCALAR_BITS iterations with dummy adds.
module ec_fp2_point_mult #(
  parameter int PT_BITS     = 2286,
  parameter int SCALAR_BITS = 381,
  parameter int FE_BITS     = 381
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [SCALAR_BITS-1:0] i_k,
  input  logic [PT_BITS-1:0]     i_p,
  input  logic                   i_val,
  output logic                   o_rdy,
  output logic [PT_BITS-1:0]     o_p,
  output logic                   o_val,
  input  logic                   i_rdy,
  output logic                   o_err,
  output logic [PT_BITS-1:0]     o_dbl_p,
  output logic                   o_dbl_val,
  input  logic                   i_dbl_rdy,
  input  logic [PT_BITS-1:0]     i_dbl_p,
  input  logic                   i_dbl_val,
  input  logic                   i_dbl_err,
  output logic                   o_dbl_rdy,
  output logic [PT_BITS-1:0]     o_add_p1,
  output logic [PT_BITS-1:0]     o_add_p2,
  output logic                   o_add_val,
  input  logic                   i_add_rdy,
  input  logic [PT_BITS-1:0]     i_add_p,
  input  logic                   i_add_val,
  input  logic                   i_add_err,
  output logic                   o_add_rdy
);

  // Z occupies the low two Fp elements of {X,Y,Z}; Z==0 marks infinity
  localparam int Z_BITS = 2 * FE_BITS;

  typedef enum logic [1:0] {IDLE, STEP, WAIT, DONE} state_t;

  state_t                 state, state_nx;
  logic [SCALAR_BITS-1:0] k_rem;
  logic [PT_BITS-1:0]     q, r, add_r;
  logic                   q_inf, err;
  logic                   dbl_pend, add_pend, dbl_req, add_req;
  logic                   add_dummy, fin;

  logic                   b;
  logic [SCALAR_BITS-1:0] k_nx;
  logic                   step_add, step_dbl, step_last, step_req, zero_short;
  logic                   dbl_hit, add_hit, dbl_done, add_done;

  assign b    = k_rem[0];
  assign k_nx = k_rem >> 1;

`ifdef EC_PT_MULT_CONST_TIME_EN
  localparam int CW = $clog2(SCALAR_BITS + 1);
  logic [CW-1:0] iter;

  assign step_add   = !q_inf;
  assign step_dbl   = 1'b1;
  assign step_last  = (iter == CW'(SCALAR_BITS - 1));
  assign zero_short = 1'b0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      iter <= '0;
    end else if (state == IDLE) begin
      iter <= '0;
    end else if (state == STEP) begin
      iter <= iter + 1'b1;
    end
  end
`else
  assign step_add   = b && !q_inf;
  assign step_dbl   = (k_nx != '0);
  assign step_last  = (k_nx == '0);
  assign zero_short = (i_k == '0);
`endif

  assign step_req = step_add || step_dbl;
  assign dbl_hit  = dbl_pend && i_dbl_val;
  assign add_hit  = add_pend && i_add_val;
  assign dbl_done = !dbl_pend || i_dbl_val;
  assign add_done = !add_pend || i_add_val;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (i_val) state_nx = zero_short ? DONE : STEP;
      STEP: begin
        if (step_req)       state_nx = WAIT;
        else if (step_last) state_nx = DONE;
        else                state_nx = STEP;
      end
      WAIT: if (dbl_done && add_done) state_nx = fin ? DONE : STEP;
      DONE: if (i_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_rdy     = !i_rst && (state == IDLE);
    o_val     = (state == DONE);
    o_err     = (state == DONE) && err;
    o_p       = q;
    o_dbl_p   = r;
    o_dbl_val = dbl_req;
    o_dbl_rdy = !i_rst && (state == IDLE || state == WAIT);
    o_add_p1  = q;
    o_add_p2  = add_r;
    o_add_val = add_req;
    o_add_rdy = !i_rst && (state == IDLE || state == WAIT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      k_rem     <= '0;
      q         <= '0;
      r         <= '0;
      add_r     <= '0;
      q_inf     <= 1'b1;
      err       <= 1'b0;
      dbl_pend  <= 1'b0;
      add_pend  <= 1'b0;
      dbl_req   <= 1'b0;
      add_req   <= 1'b0;
      add_dummy <= 1'b0;
      fin       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_val) begin
            k_rem <= i_k;
            r     <= i_p;
            q     <= '0;
            q_inf <= 1'b1;
            err   <= 1'b0;
            fin   <= 1'b0;
          end
        end
        STEP: begin
          k_rem <= k_nx;
          fin   <= step_last;
          if (b && q_inf) begin
            q     <= r;
            q_inf <= 1'b0;
          end
          // R is latched for the adder because a dbl result may overwrite it first
          if (step_add) begin
            add_req   <= 1'b1;
            add_pend  <= 1'b1;
            add_r     <= r;
            add_dummy <= !b;
          end
          if (step_dbl) begin
            dbl_req  <= 1'b1;
            dbl_pend <= 1'b1;
          end
        end
        WAIT: begin
          if (dbl_req && i_dbl_rdy) dbl_req <= 1'b0;
          if (add_req && i_add_rdy) add_req <= 1'b0;
          if (dbl_hit) begin
            r        <= i_dbl_p;
            dbl_pend <= 1'b0;
            dbl_req  <= 1'b0;
          end
          if (add_hit) begin
            add_pend <= 1'b0;
            add_req  <= 1'b0;
            if (!add_dummy) begin
              q     <= i_add_p;
              q_inf <= (i_add_p[Z_BITS-1:0] == '0);
            end
          end
          err <= err | (dbl_hit & i_dbl_err) | (add_hit & i_add_err);
        end
        default: ;
      endcase
    end
  end

endmodule
